// File: rtl/awgn_pkg.sv
// rtl/awgn_pkg.sv - shared LZD constants and tree bus offset helpers
package awgn_pkg;

  localparam int LZD_W     = 64;
  localparam int LZD_CNT_W = 6;

  // Tree results are packed level by level into flat buses.
  // Level l holds 32>>l nodes, each with one v bit and an (l+1)-bit count.
  function automatic int v_off(input int l);
    return LZD_W - (LZD_W >> l);
  endfunction

  function automatic int p_off(input int l);
    int s;
    s = 0;
    for (int j = 0; j < l; j++) s += ((LZD_W / 2) >> j) * (j + 1);
    return s;
  endfunction

  localparam int V_BUS_W = LZD_W - 1;
  localparam int P_BUS_W = 120;

endpackage

// File: rtl/lzd_node.sv
// rtl/lzd_node.sv - merges two n-bit LZD child results into one (n+1)-bit result
module lzd_node #(
  parameter int N = 1
) (
  input  logic         v_hi,
  input  logic [N-1:0] p_hi,
  input  logic         v_lo,
  input  logic [N-1:0] p_lo,
  output logic         v,
  output logic [N:0]   p
);

  assign v = v_hi | v_lo;
  assign p = v_hi ? {1'b0, p_hi} : {1'b1, p_lo};

endmodule

// File: rtl/lzd_sixtyfour.sv
// rtl/lzd_sixtyfour.sv - registered leading-zero detector, operand padded to a 64-bit tree
module lzd_sixtyfour
  import awgn_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  output logic [CNT_W-1:0]  p,
  output logic              v
);

  logic [LZD_W-1:0]   x;
  logic [V_BUS_W-1:0] v_bus;
  logic [P_BUS_W-1:0] p_bus;
  logic               v_d;
  logic [CNT_W-1:0]   p_d;

  // Operand sits at the MSB end so the tree count starts at a[DATA_W-1].
  always_comb begin
    x = '0;
    x[LZD_W-1 -: DATA_W] = a;
  end

  for (genvar i = 0; i < LZD_W / 2; i++) begin : g_leaf
    assign v_bus[i] = |x[2*i +: 2];
    assign p_bus[i] = ~x[2*i+1];
  end

  for (genvar l = 1; l < LZD_CNT_W; l++) begin : g_lvl
    for (genvar i = 0; i < ((LZD_W / 2) >> l); i++) begin : g_node
      lzd_node #(.N(l)) u_node (
        .v_hi (v_bus[v_off(l-1) + 2*i + 1]),
        .p_hi (p_bus[p_off(l-1) + (2*i+1)*l +: l]),
        .v_lo (v_bus[v_off(l-1) + 2*i]),
        .p_lo (p_bus[p_off(l-1) + (2*i)*l +: l]),
        .v    (v_bus[v_off(l) + i]),
        .p    (p_bus[p_off(l) + i*(l+1) +: l+1])
      );
    end
  end

  // An all-zero operand would otherwise report 63 from the root.
  assign v_d = v_bus[v_off(LZD_CNT_W-1)];
  assign p_d = v_d ? p_bus[p_off(LZD_CNT_W-1) +: CNT_W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      v <= 1'b0;
    end else begin
      p <= p_d;
      v <= v_d;
    end
  end

endmodule

// File: tb/tb_lzd_sixtyfour.sv
// tb/tb_lzd_sixtyfour.sv - directed and random self-checking bench for lzd_sixtyfour
module tb_lzd_sixtyfour;

  logic        clk;
  logic        rst;
  logic [47:0] a;
  logic [5:0]  p;
  logic        v;

  int total;
  int bad;

  lzd_sixtyfour #(.DATA_W(48), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .p   (p),
    .v   (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] model_p(input logic [47:0] val);
    for (int k = 47; k >= 0; k--)
      if (val[k]) return 6'(47 - k);
    return 6'd0;
  endfunction

  task automatic chk(input string tag, input logic [5:0] ep, input logic ev);
    total++;
    assert (p === ep) else begin
      bad++;
      $error("FAIL %s p: got %0d expected %0d", tag, p, ep);
    end
    total++;
    assert (v === ev) else begin
      bad++;
      $error("FAIL %s v: got %0b expected %0b", tag, v, ev);
    end
  endtask

  task automatic apply(input logic [47:0] val);
    @(negedge clk);
    a = val;
    @(posedge clk);
    #1;
  endtask

  logic [47:0] pipe_vals [5];
  logic [5:0]  pipe_p    [5];
  logic        pipe_v    [5];
  logic [47:0] r;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a     = 48'h5;
    #1;
    chk("reset_hold", 6'd0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release", 6'd45, 1'b1);

    apply(48'h0);              chk("zero",    6'd0,  1'b0);
    apply(48'h1);              chk("one",     6'd47, 1'b1);
    apply(48'h3);              chk("three",   6'd46, 1'b1);
    apply(48'h4);              chk("four",    6'd45, 1'b1);
    apply(48'h5);              chk("five",    6'd45, 1'b1);
    apply(48'h8000_0000_0000); chk("msb",     6'd0,  1'b1);
    apply(48'hFFFF_FFFF_FFFF); chk("ones",    6'd0,  1'b1);
    apply(48'h0000_8000_0000); chk("bit31",   6'd16, 1'b1);
    apply(48'h0);              chk("zero_again", 6'd0, 1'b0);

    for (int k = 0; k < 48; k++) begin
      apply(48'(1) << k);
      chk($sformatf("walk_%0d", k), 6'(47 - k), 1'b1);
    end
    for (int k = 0; k < 48; k++) begin
      r = {$urandom(), $urandom()};
      apply((48'(1) << k) | (r & ((48'(1) << k) - 48'(1))));
      chk($sformatf("walk_low_%0d", k), 6'(47 - k), 1'b1);
    end

    pipe_vals = '{48'h0, 48'h1, 48'h3, 48'h4, 48'h5};
    pipe_p    = '{6'd0, 6'd47, 6'd46, 6'd45, 6'd45};
    pipe_v    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a = pipe_vals[i];
      @(posedge clk);
      #1;
      chk($sformatf("pipe_%0d", i), pipe_p[i], pipe_v[i]);
      @(negedge clk);
    end
    a = 48'h1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset", 6'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_mid_reset", 6'd47, 1'b1);

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 9) == 0) r = 48'h0;
      else r = 48'({$urandom(), $urandom()}) >> $urandom_range(0, 47);
      apply(r);
      chk("random", model_p(r), (r != 48'h0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
